// File: rtl/index_decoder_pkg.sv
// -----------------------------------------------------------------------------
// decoder_pkg
// Shared types and constants for the index_decoder slice.
//   dec_state_t       : FSM state encoding (IDLE while waiting, HOLD while a
//                       decoded line is driven).
//   DEC_HOLD_DEFAULT  : default number of cycles a decoded line stays high.
// -----------------------------------------------------------------------------
package decoder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } dec_state_t;

  localparam int DEC_HOLD_DEFAULT = 4;

endpackage : decoder_pkg

// File: rtl/index_decoder_hold_counter.sv
// -----------------------------------------------------------------------------
// hold_counter
// Loadable down-counter that measures how long a decoded line is held.
// Loading sets the count to HOLD-1. Without a load it counts down and parks
// at zero.
// Ports:
//   clk     : rising-edge clock
//   reset   : asynchronous active-high reset (count -> 0)
//   i_load  : load HOLD-1 on the next edge (takes priority over counting)
//   o_cnt   : current count
//   o_zero  : high when the count is zero (combinational from the register)
// -----------------------------------------------------------------------------
module hold_counter #(
  parameter int HOLD = decoder_pkg::DEC_HOLD_DEFAULT,
  parameter int CW   = $clog2(HOLD + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  output logic [CW-1:0] o_cnt,
  output logic          o_zero
);

  localparam logic [CW-1:0] LOAD_VAL = CW'(HOLD - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  logic [CW-1:0] r_cnt;

  // Count register: load on accept, otherwise decrement until zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= CNT_ZERO;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (r_cnt != CNT_ZERO) begin
      r_cnt <= r_cnt - CNT_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == CNT_ZERO);

endmodule : hold_counter

// File: rtl/index_decoder.sv
// -----------------------------------------------------------------------------
// index_decoder
// Registered binary-to-one-hot decoder with hold timing. It accepts an encoded
// index plus its valid flag over a ready/valid handshake. It drives line y of
// a one-hot vector for HOLD cycles and then releases the line. A code accepted
// on the final hold cycle reloads the vector with no dead cycle in between.
// Ports:
//   clk      : rising-edge clock
//   reset    : asynchronous active-high reset
//   in_valid : producer offers {y, valid} this cycle
//   in_ready : decoder can accept this cycle (registered state only)
//   y        : encoded index, N bits
//   valid    : encoder valid flag; 0 means "no request"
//   a        : registered one-hot (or all-zero) vector, 2**N bits
//   busy     : registered, high while a line is held
//   done     : registered one-cycle pulse when a hold ends without reload
// -----------------------------------------------------------------------------
module index_decoder #(
  parameter int N    = 2,
  parameter int HOLD = decoder_pkg::DEC_HOLD_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      y,
  input  logic              valid,
  output logic [2**N-1:0]   a,
  output logic              busy,
  output logic              done
);

  import decoder_pkg::dec_state_t;
  import decoder_pkg::IDLE;

  localparam int              W     = 2**N;
  localparam int              CW    = $clog2(HOLD + 1);
  localparam logic [W-1:0]    LINE0 = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]    NONE  = {W{1'b0}};

  dec_state_t      r_state;
  logic [W-1:0]    r_a;
  logic            r_busy;
  logic            r_done;

  logic            w_in_ready;
  logic            w_load;
  logic            w_cnt_zero;
  logic [CW-1:0]   w_cnt;
  logic [W-1:0]    w_dec;

  hold_counter #(
    .HOLD (HOLD),
    .CW   (CW)
  ) u_hold_counter (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_load),
    .o_cnt  (w_cnt),
    .o_zero (w_cnt_zero)
  );

  // Ready only from registered state so in_valid never loops back into it.
  always_comb begin
    w_in_ready = 1'b1;
    case (r_state)
      IDLE:              w_in_ready = 1'b1;
      decoder_pkg::HOLD: w_in_ready = w_cnt_zero;
      default:           w_in_ready = 1'b1;
    endcase
  end

  // Only a transfer carrying valid=1 starts or reloads a hold; valid=0 codes
  // are consumed and dropped.
  assign w_load = in_valid && w_in_ready && valid;
  assign w_dec  = LINE0 << y;

  // Decode FSM: drive the line while holding, release or reload at cnt==0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_a     <= NONE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_load) begin
            r_a     <= w_dec;
            r_busy  <= 1'b1;
            r_state <= decoder_pkg::HOLD;
          end else begin
            r_a     <= NONE;
            r_busy  <= 1'b0;
          end
        end
        decoder_pkg::HOLD: begin
          if (w_cnt_zero) begin
            if (w_load) begin
              r_a <= w_dec;
            end else begin
              r_a     <= NONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= IDLE;
            end
          end else begin
            r_a <= r_a;
          end
        end
        default: begin
          r_a     <= NONE;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready = w_in_ready;
  assign a        = r_a;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule : index_decoder

// File: tb/tb_index_decoder.sv
// -----------------------------------------------------------------------------
// tb_index_decoder
// Two decoders (HOLD=4 and HOLD=1, N=2). Accepted codes push their expected
// output cycles into a per-instance queue; a negedge monitor pops one entry per
// cycle and compares a, busy, done, in_ready and the one-hot property.
// -----------------------------------------------------------------------------
module tb_index_decoder;

  localparam int HOLDV [2] = '{4, 1};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid_i [2];
  logic [1:0] y_i        [2];
  logic       valid_i    [2];
  logic       in_ready_o [2];
  logic [3:0] a_o        [2];
  logic       busy_o     [2];
  logic       done_o     [2];

  logic [3:0] exp_q [2][$];
  bit         prev_pop [2];
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  index_decoder #(.N(2), .HOLD(4)) dut4 (
    .clk(clk), .reset(rst), .in_valid(in_valid_i[0]), .in_ready(in_ready_o[0]),
    .y(y_i[0]), .valid(valid_i[0]), .a(a_o[0]), .busy(busy_o[0]), .done(done_o[0])
  );

  index_decoder #(.N(2), .HOLD(1)) dut1 (
    .clk(clk), .reset(rst), .in_valid(in_valid_i[1]), .in_ready(in_ready_o[1]),
    .y(y_i[1]), .valid(valid_i[1]), .a(a_o[1]), .busy(busy_o[1]), .done(done_o[1])
  );

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d at %0t: actual=%0h expected=%0h", name, d, $time, act, exp);
    end
  endtask

  // Monitor: model says whether a line is due this cycle; DUT must match.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [3:0] ea;
      bit         popped;
      if (rst) begin
        exp_q[d].delete();
        prev_pop[d] = 1'b0;
        chk("rst_a", d, a_o[d], 0);
        chk("rst_busy", d, busy_o[d], 0);
        chk("rst_done", d, done_o[d], 0);
        chk("rst_in_ready", d, in_ready_o[d], 1);
      end else begin
        popped = (exp_q[d].size() > 0);
        ea     = popped ? exp_q[d].pop_front() : 4'd0;
        chk("a", d, a_o[d], ea);
        chk("busy", d, busy_o[d], popped);
        chk("done", d, done_o[d], prev_pop[d] && !popped);
        chk("in_ready", d, in_ready_o[d], exp_q[d].size() == 0);
        chk("onehot", d, $countones(a_o[d]) <= 1, 1);
        prev_pop[d] = popped;
      end
    end
  end

  // One cycle of stimulus, called at negedge+1; records an accepted transfer.
  task automatic drive_cycle(input int d, input bit iv, input logic [1:0] yy, input bit vv, output bit took);
    in_valid_i[d] = iv;
    y_i[d]        = yy;
    valid_i[d]    = vv;
    took = iv && in_ready_o[d];
    if (took && vv) begin
      for (int k = 0; k < HOLDV[d]; k++) exp_q[d].push_back(4'(1 << yy));
    end
    @(negedge clk);
    #1;
  endtask

  task automatic send(input int d, input logic [1:0] yy, input bit vv);
    bit took = 1'b0;
    for (int t = 0; t < 50 && !took; t++) drive_cycle(d, 1'b1, yy, vv, took);
    if (!took) chk("accept_timeout", d, 0, 1);
  endtask

  task automatic idle(input int d, input int cycles);
    bit took;
    for (int t = 0; t < cycles; t++) drive_cycle(d, 1'b0, 2'd0, 1'b0, took);
  endtask

  task automatic rand_drive(input int d, input int cycles);
    bit         iv = 1'b0;
    bit         took = 1'b1;
    logic [1:0] yy = 2'd0;
    bit         vv = 1'b0;
    for (int t = 0; t < cycles; t++) begin
      // Producer keeps an unaccepted offer stable.
      if (!(iv && !took)) begin
        iv = ($urandom_range(0, 3) != 0);
        yy = 2'($urandom_range(0, 3));
        vv = ($urandom_range(0, 4) != 0);
      end
      drive_cycle(d, iv, yy, vv, took);
    end
    idle(d, 8);
  endtask

  // Index a priority encoder reports for request vector n (highest set bit).
  function automatic logic [1:0] enc_index(input int n);
    logic [1:0] r = 2'd0;
    for (int b = 0; b < 4; b++) if ((n >> b) % 2 == 1) r = 2'(b);
    return r;
  endfunction

  initial begin
    for (int d = 0; d < 2; d++) begin
      in_valid_i[d] = 1'b0;
      y_i[d]        = 2'd0;
      valid_i[d]    = 1'b0;
    end
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;

    // Single code, valid=0 drop, back-to-back stream, backpressure.
    send(0, 2'd1, 1'b1); idle(0, 6);
    send(0, 2'd3, 1'b0); idle(0, 3);
    send(0, 2'd0, 1'b1); send(0, 2'd3, 1'b1); send(0, 2'd2, 1'b1); idle(0, 6);
    send(0, 2'd3, 1'b1); send(0, 2'd1, 1'b1); idle(0, 6);

    // HOLD=1 sweep over all request vectors.
    for (int n = 0; n < 16; n++) send(1, enc_index(n), n != 0);
    idle(1, 3);

    // Reset in the middle of a hold.
    send(0, 2'd2, 1'b1); idle(0, 2);
    rst = 1'b1;
    exp_q[0].delete();
    exp_q[1].delete();
    #1;
    chk("midrst_a", 0, a_o[0], 0);
    chk("midrst_busy", 0, busy_o[0], 0);
    chk("midrst_done", 0, done_o[0], 0);
    @(negedge clk);
    #1 rst = 1'b0;
    idle(0, 2);

    // Randomized traffic on both instances.
    fork
      rand_drive(0, 300);
      rand_drive(1, 300);
    join

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_index_decoder

// File: doc/index_decoder.md
# index_decoder

Registered binary-to-one-hot decoder with hold timing. It sits on the consumer side of the 4-request priority encoder. It accepts an encoded index plus its valid flag over a ready/valid handshake and drives exactly one line of a one-hot vector for a programmable number of cycles. It then releases the line and accepts the next code, with no dead cycle when a new code is waiting.

## Interface
- N, default 2: index width; output vector is 2**N bits.
- HOLD, default 4: cycles each decoded line stays high; legal range 1..255.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer offers {y, valid} this cycle.
- in_ready  output  1  decoder can accept this cycle.
- y  input  N  encoded index, as produced by the priority encoder.
- valid  input  1  encoder valid flag; 0 means "no request".
- a  output  2**N  registered one-hot (or all-zero) decoded vector.
- busy  output  1  registered; high while a line is being held.
- done  output  1  registered one-cycle pulse when a hold ends without reload.

## Operation
- A transfer occurs on a rising edge where in_valid && in_ready.
- States: IDLE, HOLD.
- IDLE behaviour:
  - in_ready = 1.
  - If a transfer occurs with valid=1: a <= 1 << y, cnt <= HOLD-1, busy <= 1, go to HOLD.
  - If a transfer occurs with valid=0: code consumed and dropped; a stays 0; stay in IDLE; done not asserted.
- HOLD behaviour:
  - in_ready = (cnt == 0), combinational from registered state.
  - While cnt != 0: cnt decrements each cycle; a held.
  - When cnt == 0 and a transfer occurs with valid=1: reload a, cnt <= HOLD-1; stay in HOLD; no done.
  - When cnt == 0 and a transfer occurs with valid=0: a <= 0, busy <= 0, done <= 1, go to IDLE.
  - When cnt == 0 and there is no transfer: a <= 0, busy <= 0, done <= 1, go to IDLE.
- Output rules:
  - a is never multi-hot.
  - y values are all legal, since 2**N lines cover the full range.
- cnt width is $clog2(HOLD+1). For HOLD=1, cnt is always 0, in_ready is always 1, and every valid transfer produces a 1-cycle pulse.
- done is high for exactly one cycle per released hold, otherwise 0.

## Timing
- Reset (asynchronous, any time including mid-hold):
  - a=0, busy=0, done=0, cnt=0, state=IDLE.
  - in_ready=1 immediately after reset deasserts.
- Latency: a transfer at edge k makes a valid after edge k. The line is high for exactly HOLD cycles, k..k+HOLD-1 edges inclusive.
- done pulses in the cycle after the last hold cycle, coincident with a falling to 0.
- Back-to-back transfers: a new code accepted on the final hold cycle produces contiguous output. The old line falls and the new line rises on the same edge. Same index back-to-back gives a line that stays high for 2*HOLD cycles.
- in_ready does not depend on in_valid combinationally (no loop).
- The producer must hold {y, valid} stable while in_valid=1 && in_ready=0.

## Structure
- Shared package decoder_pkg holds:
  - typedef enum logic {IDLE, HOLD} dec_state_t;
  - localparam-style helper constant for the default HOLD.
- One sub-module is natural: hold_counter, a loadable down-counter with a zero flag, parameterised by HOLD.
- Decode logic and the FSM live in index_decoder.

## Test plan
- Reset mid-hold: accept y=2, valid=1, then assert reset 2 cycles later -> a=0, busy=0, done=0 at once; in_ready=1 after release.
- Single code, N=2, HOLD=4: send y=1, valid=1 once -> a=4'b0010 for exactly 4 cycles; then a=0, busy=0, and done=1 for 1 cycle.
- valid=0 code in IDLE: send y=3, valid=0 -> accepted (in_ready=1); a stays 4'b0000; done stays 0; busy stays 0.
- Back-to-back: stream y=0,3,2 (valid=1) with in_valid held high -> in_ready high only on final hold cycles; a = 0001 x4, 1000 x4, 0100 x4 with no gaps; a single done after the last.
- HOLD=1 sweep: for n=0..15 send y=expected encoder index of n and valid=(n!=0) each cycle -> a = 1<<y for one cycle, or 0 for n=0; in_ready always 1; one-hot checked every cycle.
- Backpressure stability: present y=1 while busy with y=3 and keep in_valid high -> y=1 is not accepted until cnt=0; then a switches 1000 -> 0010 on that edge.
